// File: rtl/beep_pkg.sv
// Shared types and constants for the beep arbiter: FSM states, field widths
// and the tone half-period table (C4..B4 at a 50 MHz system clock).
package beep_pkg;
  localparam int N_REQ  = 3;
  localparam int TONE_W = 3;
  localparam int DUR_W  = 8;
  localparam int HP_W   = 17;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  function automatic logic [HP_W-1:0] half_period(input logic [TONE_W-1:0] tone);
    case (tone)
      3'd1:    return 17'd95420;
      3'd2:    return 17'd85034;
      3'd3:    return 17'd75758;
      3'd4:    return 17'd71633;
      3'd5:    return 17'd63776;
      3'd6:    return 17'd56818;
      3'd7:    return 17'd50607;
      default: return 17'd0;
    endcase
  endfunction
endpackage

// File: rtl/beep_arbiter_tone_gen.sv
// Square-wave generator: toggles its output every half_i enabled cycles.
// A synchronous clear restarts the wave low with the counter at zero.
module tone_gen
  import beep_pkg::*;
(
  input  logic            sys_clk_i,
  input  logic            ext_rst_n,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [HP_W-1:0] half_i,
  output logic            tone_o
);
  logic [HP_W-1:0] cnt_q;
  logic            tone_q;

  always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (en_i) begin
      if ({1'b0, cnt_q} + 1'b1 >= {1'b0, half_i}) begin
        cnt_q  <= '0;
        tone_q <= ~tone_q;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign tone_o = tone_q;
endmodule

// File: rtl/beep_arbiter.sv
// Fixed-priority arbiter for a single buzzer: grants one requester, plays its
// tone for dur ms, pulses done, then enforces a silent gap before re-arbitrating.
module beep_arbiter
  import beep_pkg::*;
#(
  parameter int              MS_DIV = 50000,
  parameter int              GAP_MS = 5,
  parameter logic [HP_W-1:0] HP_OVR = '0   // nonzero replaces the table for every tone
) (
  input  logic                    sys_clk_i,
  input  logic                    ext_rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*TONE_W-1:0] tone_i,
  input  logic [N_REQ*DUR_W-1:0]  dur_i,
  input  logic                    stop_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    busy_o,
  output logic                    beep
);
  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, gnt_idx;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic [DUR_W-1:0]  dur_q, dur_d, cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]     ms_q, ms_d;
  logic [N_REQ-1:0]  ack_q, ack_d, done_q, done_d;
  logic              tick, play_end, gap_end;

  always_comb begin
    gnt_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (req_i[k]) gnt_idx = IDX_W'(k);
  end

  assign tick     = (ms_q == PW'(MS_DIV-1));
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // dur==0 exits on the very first PLAY cycle; stop and expiry share one exit
  assign play_end = stop_i || (dur_q == '0) || (tick && cnt_inc == dur_q);
  assign gap_end  = tick && (cnt_inc == DUR_W'(GAP_MS));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    ack_d   = '0;
    done_d  = '0;
    ms_d    = tick ? '0 : ms_q + 1'b1;
    cnt_d   = tick ? cnt_inc : cnt_q;
    case (state_q)
      IDLE: begin
        ms_d  = '0;
        cnt_d = '0;
        if (|req_i) begin
          state_d        = PLAY;
          idx_d          = gnt_idx;
          tone_d         = tone_i[TONE_W*gnt_idx +: TONE_W];
          dur_d          = dur_i[DUR_W*gnt_idx +: DUR_W];
          ack_d[gnt_idx] = 1'b1;
        end
      end
      PLAY: begin
        if (play_end) begin
          state_d      = GAP;
          done_d[idx_q] = 1'b1;
          ms_d         = '0;
          cnt_d        = '0;
        end
      end
      GAP: begin
        if (gap_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tone_q  <= '0;
      dur_q   <= '0;
      ms_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      dur_q   <= dur_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  logic            tg_en, tg_clr;
  logic [HP_W-1:0] tg_half;

  // clearing on the exit edge forces beep low in the same cycle done rises
  assign tg_en   = (state_q == PLAY) && (tone_q != '0);
  assign tg_clr  = (state_q != PLAY) || (state_d != PLAY);
  assign tg_half = (HP_OVR != '0) ? HP_OVR : half_period(tone_q);

  tone_gen u_tone_gen (
    .sys_clk_i (sys_clk_i),
    .ext_rst_n (ext_rst_n),
    .en_i      (tg_en),
    .clr_i     (tg_clr),
    .half_i    (tg_half),
    .tone_o    (beep)
  );

  assign ack_o  = ack_q;
  assign done_o = done_q;
  assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_beep_arbiter.sv
// Directed bench for beep_arbiter with MS_DIV=100, GAP_MS=2 and a 10-cycle
// half-period override so tones audibly toggle within short plays.
module tb_beep_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_i;
  logic [8:0]  tone_i;
  logic [23:0] dur_i;
  logic        stop_i;
  logic [2:0]  ack_o, done_o;
  logic        busy_o, beep;

  int nchk = 0;
  int nerr = 0;

  beep_arbiter #(.MS_DIV(100), .GAP_MS(2), .HP_OVR(17'd10)) dut (
    .sys_clk_i (clk),
    .ext_rst_n (rst_n),
    .req_i     (req_i),
    .tone_i    (tone_i),
    .dur_i     (dur_i),
    .stop_i    (stop_i),
    .ack_o     (ack_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .beep      (beep)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int rises, first;
    logic prev, bh;
    rst_n = 1'b0; req_i = '0; tone_i = '0; dur_i = '0; stop_i = 1'b0;
    step(2);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_beep", 32'(beep), 0);
    chk("rst_ack",  32'(ack_o), 0);
    chk("rst_done", 32'(done_o), 0);
    rst_n = 1'b1;
    step(1);

    // lower index 1 wins over 2; dur 3 ms -> 300 cycles, gap 200 cycles
    tone_i = {3'd0, 3'd1, 3'd0}; dur_i = {8'd0, 8'd3, 8'd0}; req_i = 3'b110;
    step(1);
    chk("t1_ack", 32'(ack_o), 32'b010);
    chk("t1_busy", 32'(busy_o), 1);
    req_i = '0;
    step(1);   chk("t1_ack_1cyc", 32'(ack_o), 0);
    step(298); chk("t1_done_early", 32'(done_o), 0);
    step(1);   chk("t1_done", 32'(done_o), 32'b010);
    step(199); chk("t1_gap_busy", 32'(busy_o), 1);
    step(1);   chk("t1_idle", 32'(busy_o), 0);

    // tone 7, dur 2, 20-cycle period: first rise at cycle 10, 10 rises
    tone_i = {3'd0, 3'd0, 3'd7}; dur_i = {8'd0, 8'd0, 8'd2}; req_i = 3'b001;
    step(1);
    chk("t2_ack", 32'(ack_o), 32'b001);
    chk("t2_beep0", 32'(beep), 0);
    req_i = '0;
    rises = 0; first = -1; prev = 1'b0;
    for (int c = 1; c < 200; c++) begin
      step(1);
      if (beep && !prev) begin
        rises++;
        if (first < 0) first = c;
      end
      prev = beep;
    end
    chk("t2_first_rise", 32'(first), 10);
    chk("t2_rises", 32'(rises), 10);
    step(1);
    chk("t2_done", 32'(done_o), 32'b001);
    chk("t2_beep_off", 32'(beep), 0);
    step(199); chk("t2_gap_busy", 32'(busy_o), 1);
    step(1);   chk("t2_idle", 32'(busy_o), 0);

    // dur 0: done the cycle after ack, silent, then 200-cycle gap
    tone_i = {3'd5, 3'd0, 3'd0}; dur_i = '0; req_i = 3'b100;
    step(1);
    chk("t3_ack", 32'(ack_o), 32'b100);
    req_i = '0;
    step(1);
    chk("t3_done", 32'(done_o), 32'b100);
    chk("t3_beep", 32'(beep), 0);
    bh = 1'b0;
    for (int c = 2; c <= 200; c++) begin
      step(1);
      bh |= beep;
    end
    chk("t3_gap_busy", 32'(busy_o), 1);
    chk("t3_silent", 32'(bh), 0);
    step(1); chk("t3_idle", 32'(busy_o), 0);

    // stop at cycle 57 of a 10 ms play; second stop in GAP is ignored
    tone_i = {3'd0, 3'd0, 3'd3}; dur_i = {8'd0, 8'd0, 8'd10}; req_i = 3'b001;
    step(1);
    chk("t4_ack", 32'(ack_o), 32'b001);
    req_i = '0;
    step(57);
    chk("t4_beep_on", 32'(beep), 1);
    chk("t4_no_done", 32'(done_o), 0);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("t4_done", 32'(done_o), 32'b001);
    chk("t4_beep_off", 32'(beep), 0);
    chk("t4_gap", 32'(busy_o), 1);
    step(42);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("t4_gap_stop_done", 32'(done_o), 0);
    chk("t4_gap_stop_busy", 32'(busy_o), 1);
    step(156); chk("t4_gap_end_busy", 32'(busy_o), 1);
    step(1);   chk("t4_idle", 32'(busy_o), 0);

    // all three held: index 0 starves the others until it drops
    tone_i = '0; dur_i = '0; req_i = 3'b111;
    step(1);   chk("t5_ack0", 32'(ack_o), 32'b001);
    step(1);   chk("t5_done0", 32'(done_o), 32'b001);
    step(200); chk("t5_noack_idle", 32'(ack_o), 0);
    chk("t5_idle", 32'(busy_o), 0);
    step(1);   chk("t5_ack0_again", 32'(ack_o), 32'b001);
    req_i = 3'b110;
    step(201); chk("t5_noack2", 32'(ack_o), 0);
    step(1);   chk("t5_ack1", 32'(ack_o), 32'b010);
    req_i = '0;
    step(201); chk("t5_idle2", 32'(busy_o), 0);

    // reset mid-play: immediate silence, no done, pending request re-granted
    tone_i = {3'd0, 3'd0, 3'd7}; dur_i = {8'd0, 8'd0, 8'd5}; req_i = 3'b001;
    step(1);   chk("t6_ack", 32'(ack_o), 32'b001);
    step(12);
    chk("t6_beep_on", 32'(beep), 1);
    chk("t6_ignored_req", 32'(ack_o), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_beep", 32'(beep), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_done", 32'(done_o), 0);
    step(3);
    chk("t6_rst_hold_done", 32'(done_o), 0);
    rst_n = 1'b1;
    step(1);
    chk("t6_regrant", 32'(ack_o), 32'b001);
    chk("t6_no_done", 32'(done_o), 0);
    req_i = '0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
